// File: rtl/alloc_pkg.sv
// Shared constants and helpers for the linked-memory cell allocator protocol.
package alloc_pkg;

    localparam logic [15:0] UNDEF = 16'h0000;
    localparam logic [15:0] NIL   = 16'h0001;
    localparam logic [15:0] BASE  = 16'h4000;

    // A cell address is valid when its high bits match BASE and its index is below the top mark.
    function automatic logic addr_valid(input logic [15:0] addr,
                                        input logic [15:0] top,
                                        input int unsigned addr_sz);
        logic [15:0] mask;
        mask = (16'd1 << addr_sz) - 16'd1;
        return ((addr & ~mask) == BASE) && ((addr & mask) < top);
    endfunction

endpackage

// File: rtl/cell_ram.sv
// Synchronous 1R1W cell store, read-first on same-address collision.
module cell_ram #(
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_SZ-1:0] i_waddr,
    input  logic [15:0]        i_wdata,
    input  logic [ADDR_SZ-1:0] i_raddr,
    output logic [15:0]        o_rdata
);

    logic [15:0] r_mem [2**ADDR_SZ];

    // Registered read every cycle plus optional write.
    // NOTE: no reset here so the array maps onto block RAM; callers qualify o_rdata with their own reset-cleared valid flags.
    always_ff @(posedge i_clk) begin
        // NOTE: both updates are non-blocking, so a same-address read sees the value from before this write (read-first).
        o_rdata <= r_mem[i_raddr];
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/cell_pool.sv
// Cell allocator: top-of-memory mark, prefetched free list, error flag, shared RAM read port.
module cell_pool
    import alloc_pkg::*;
#(
    parameter int ADDR_SZ = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_alloc,
    input  logic [15:0]      i_data,
    output logic [15:0]      o_addr,
    input  logic             i_free,
    input  logic [15:0]      i_addr,
    input  logic             i_wr,
    input  logic [15:0]      i_waddr,
    input  logic [15:0]      i_wdata,
    input  logic             i_rd,
    input  logic [15:0]      i_raddr,
    output logic [15:0]      o_rdata,
    output logic [ADDR_SZ:0] o_used,
    output logic             o_err
);

    localparam logic [ADDR_SZ:0] TOP_MAX = {1'b1, {ADDR_SZ{1'b0}}};
    localparam logic [ADDR_SZ:0] ONE     = 1;

    logic [ADDR_SZ:0] r_top;
    logic [ADDR_SZ:0] r_used;
    logic [15:0]      r_head;
    logic [15:0]      r_next;
    logic [15:0]      r_addr;
    logic [15:0]      r_rdata;
    logic             r_pf_pending;
    logic             r_rd_valid;
    logic             r_err;

    logic [15:0]        w_ram_q;
    logic [15:0]        w_next;
    logic [15:0]        w_top16;
    logic [15:0]        w_cell;
    logic [15:0]        w_rdata;
    logic               w_from_list;
    logic               w_error;
    logic               w_do_alloc;
    logic               w_do_free;
    logic               w_do_wr;
    logic               w_do_rd;
    logic               w_ram_we;
    logic [ADDR_SZ-1:0] w_ram_waddr;
    logic [15:0]        w_ram_wdata;
    logic [ADDR_SZ-1:0] w_ram_raddr;

    // Request decode, error detection, prefetch bypass and RAM port steering.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_next      = r_pf_pending ? w_ram_q : r_next;
        w_top16     = 16'(r_top);
        w_from_list = (r_head != NIL);
        w_cell      = w_from_list ? r_head : (BASE | w_top16);
        w_rdata     = r_rd_valid ? w_ram_q : r_rdata;

        w_error = (i_alloc && (i_free || i_wr || i_rd))
               || (i_free && (i_wr || i_rd))
               || (i_alloc && !w_from_list && (r_top == TOP_MAX))
               || (i_free && !addr_valid(i_addr, w_top16, ADDR_SZ))
               || (i_rd && !addr_valid(i_raddr, w_top16, ADDR_SZ))
               || (i_wr && !addr_valid(i_waddr, w_top16, ADDR_SZ));

        w_do_alloc = i_alloc && !w_error;
        w_do_free  = i_free && !w_error;
        w_do_wr    = i_wr && !w_error;
        w_do_rd    = i_rd && !w_error;

        w_ram_we    = 1'b0;
        w_ram_waddr = i_waddr[ADDR_SZ-1:0];
        w_ram_wdata = i_wdata;
        if (w_do_alloc) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_cell[ADDR_SZ-1:0];
            w_ram_wdata = i_data;
        end else if (w_do_free) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = i_addr[ADDR_SZ-1:0];
            w_ram_wdata = r_head;
        end else if (w_do_wr) begin
            w_ram_we = 1'b1;
        end

        // An allocation never coexists with a user read, so it owns the read port for its prefetch.
        w_ram_raddr = w_do_alloc ? w_next[ADDR_SZ-1:0] : i_raddr[ADDR_SZ-1:0];
    end

    // Allocator state, output registers and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_top        <= '0;
            r_used       <= '0;
            r_head       <= NIL;
            r_next       <= NIL;
            r_addr       <= UNDEF;
            r_rdata      <= UNDEF;
            r_pf_pending <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err        <= r_err | w_error;
            r_rd_valid   <= w_do_rd;
            r_rdata      <= w_rdata;
            r_next       <= w_next;
            r_pf_pending <= 1'b0;
            if (w_do_alloc) begin
                r_addr <= w_cell;
                r_used <= r_used + ONE;
                if (w_from_list) begin
                    r_head       <= w_next;
                    r_pf_pending <= (w_next != NIL);
                end else begin
                    r_top <= r_top + ONE;
                end
            end else if (w_do_free) begin
                r_next <= r_head;
                r_head <= i_addr;
                r_used <= r_used - ONE;
            end
        end
    end

    cell_ram #(.ADDR_SZ(ADDR_SZ)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    assign o_addr  = r_addr;
    assign o_rdata = w_rdata;
    assign o_used  = r_used;
    assign o_err   = r_err;

endmodule

// File: tb/tb_cell_pool.sv
// Directed self-checking bench for cell_pool with ADDR_SZ = 8.
module tb_cell_pool;

    localparam int ADDR_SZ = 8;

    logic             clk;
    logic             rst_n;
    logic             alloc;
    logic [15:0]      data;
    logic [15:0]      addr_o;
    logic             free;
    logic [15:0]      faddr;
    logic             wr;
    logic [15:0]      waddr;
    logic [15:0]      wdata;
    logic             rd;
    logic [15:0]      raddr;
    logic [15:0]      rdata;
    logic [ADDR_SZ:0] used;
    logic             err;

    int checks = 0;
    int errors = 0;

    cell_pool #(.ADDR_SZ(ADDR_SZ)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_alloc (alloc),
        .i_data  (data),
        .o_addr  (addr_o),
        .i_free  (free),
        .i_addr  (faddr),
        .i_wr    (wr),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_rd    (rd),
        .i_raddr (raddr),
        .o_rdata (rdata),
        .o_used  (used),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc = 0; free = 0; wr = 0; rd = 0;
        data = 16'h0; faddr = 16'h0; waddr = 16'h0; wdata = 16'h0; raddr = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_alloc(input logic [15:0] d);
        alloc = 1; data = d;
        tick();
    endtask

    task automatic do_free(input logic [15:0] a);
        free = 1; faddr = a;
        tick();
    endtask

    task automatic do_read(input logic [15:0] a);
        rd = 1; raddr = a;
        tick();
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 0;
        #2 rst_n = 1;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, 32'(addr_o), 32'h0000);
        check({tag, "_rdata"}, 32'(rdata), 32'h0000);
        check({tag, "_used"}, 32'(used), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_reset_state("rst");

        // Three fresh allocations from the top mark.
        do_alloc(16'h0001); check("alloc0", 32'(addr_o), 32'h4000);
        do_alloc(16'h4000); check("alloc1", 32'(addr_o), 32'h4001);
        do_alloc(16'h4001); check("alloc2", 32'(addr_o), 32'h4002);
        check("used3", 32'(used), 32'd3);
        check("err_a", 32'(err), 32'd0);

        // Reads, read-first collision, then read-back.
        do_read(16'h4002); check("rd4002", 32'(rdata), 32'h4001);
        rd = 1; raddr = 16'h4001; wr = 1; waddr = 16'h4001; wdata = 16'h1234;
        tick(); check("rw_old", 32'(rdata), 32'h4000);
        tick(); check("rd_hold", 32'(rdata), 32'h4000);
        do_read(16'h4001); check("rd_new", 32'(rdata), 32'h1234);

        // Free two cells, then reuse them back to back from the free list.
        do_free(16'h4001);
        do_free(16'h4000); check("used1", 32'(used), 32'd1);
        do_alloc(16'h00AA); check("list0", 32'(addr_o), 32'h4000);
        do_alloc(16'h00BB); check("list1", 32'(addr_o), 32'h4001);
        check("used3b", 32'(used), 32'd3);
        check("rd_undisturbed", 32'(rdata), 32'h1234);
        do_alloc(16'h00CC); check("top_kept", 32'(addr_o), 32'h4003);
        check("err_b", 32'(err), 32'd0);

        // Fill the pool, then overflow once.
        for (int i = 4; i < 256; i++) do_alloc(16'(i));
        check("fill_addr", 32'(addr_o), 32'h40FF);
        check("fill_used", 32'(used), 32'd256);
        check("fill_err", 32'(err), 32'd0);
        do_alloc(16'h0000);
        check("full_err", 32'(err), 32'd1);
        check("full_addr", 32'(addr_o), 32'h40FF);
        check("full_used", 32'(used), 32'd256);
        tick(); check("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 0;
        #1 check_reset_state("arst");
        #1 rst_n = 1;
        tick();

        // Read past the top mark.
        do_alloc(16'h0); do_alloc(16'h0); do_alloc(16'h0);
        do_read(16'h4005);
        check("bad_rd_err", 32'(err), 32'd1);
        check("bad_rd_data", 32'(rdata), 32'h0000);
        do_reset();

        // Allocate combined with a read.
        do_alloc(16'h0);
        alloc = 1; rd = 1; raddr = 16'h4000;
        tick();
        check("combo_err", 32'(err), 32'd1);
        check("combo_addr", 32'(addr_o), 32'h4000);
        check("combo_used", 32'(used), 32'd1);
        do_reset();
        check_reset_state("rst2");

        // Fill and drain twice; the second fill comes entirely from the free list.
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 256; i++) begin
                do_alloc(16'(i));
                check(run == 0 ? "fill_top" : "fill_list", 32'(addr_o),
                      (run == 0) ? 32'h4000 + 32'(i) : 32'h40FF - 32'(i));
            end
            check("run_used_full", 32'(used), 32'd256);
            for (int i = 0; i < 256; i++) do_free(16'h4000 + 16'(i));
            check("run_used_empty", 32'(used), 32'd0);
            check("run_err", 32'(err), 32'd0);
        end
        do_alloc(16'h0);
        check("reuse_after", 32'(addr_o), 32'h40FF);
        check("reuse_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
